// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu -- load/store initiator for the word-wide synchronous datamemory.
//
// Takes one byte-addressed load or store at a time over a valid/ready
// handshake, converts it to a word access (read-modify-write for byte and
// halfword stores) and returns aligned, extended load data as a one-cycle
// response pulse. Memory is big-endian: byte offset 0 is bits [31:24].
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; ready is high only when idle
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed        sign-extend sub-word loads
//   req_addr          byte address (bits [ADDR_W+1:2] select the word)
//   req_wdata         right-justified store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        formatted load data, 0 for stores and errors
//   resp_err          misaligned or reserved-size request
//   mem_address       word address to datamemory
//   mem_data_in       write data to datamemory
//   mem_we            write enable to datamemory
//   mem_data_out      read data from datamemory, one cycle after address
// ---------------------------------------------------------------------------
module dmem_lsu #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data_in,
   output logic              mem_we,
   input  logic [31:0]       mem_data_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   state_e      state_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;
   logic        err_q;

   logic              req_err_d;
   logic [ADDR_W-1:0] widx_d;
   logic              unused_addr_d;

   // Extract the addressed byte/half from a big-endian word and extend it.
   function automatic logic [31:0] load_format(input logic [31:0] w,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic        sg);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (sz)
         2'b00:   r = {{24{sg & b[7]}}, b};
         2'b01:   r = {{16{sg & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Insert the low byte/half of the store data into the addressed lane.
   function automatic logic [31:0] store_merge(input logic [31:0] w,
                                               input logic [31:0] wd,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off);
      logic [31:0] r;
      r = w;
      case (sz)
         2'b00: begin
            case (off)
               2'd0:    r[31:24] = wd[7:0];
               2'd1:    r[23:16] = wd[7:0];
               2'd2:    r[15:8]  = wd[7:0];
               default: r[7:0]   = wd[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) begin
               r[15:0] = wd[15:0];
            end else begin
               r[31:16] = wd[15:0];
            end
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   // Alignment and size checks on the incoming request.
   always_comb begin
      req_err_d = 1'b0;
      case (req_size)
         2'b00:   req_err_d = 1'b0;
         2'b01:   req_err_d = req_addr[0];
         2'b10:   req_err_d = (req_addr[1:0] != 2'b00);
         default: req_err_d = 1'b1;
      endcase
   end

   // Upper address bits are deliberately ignored so addresses alias.
   assign widx_d        = req_addr[ADDR_W+1:2];
   assign unused_addr_d = ^req_addr[31:ADDR_W+2];

   assign req_ready = (state_q == S_IDLE);

   // Control FSM with all memory-side and response outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         sign_q      <= 1'b0;
         off_q       <= 2'b00;
         wdata_q     <= 32'd0;
         word_q      <= 32'd0;
         err_q       <= 1'b0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= 32'd0;
         mem_we      <= 1'b0;
         mem_address <= {ADDR_W{1'b0}};
         mem_data_in <= 32'd0;
      end else begin
         // Pulses default low; each state re-asserts what it needs.
         mem_we     <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  sign_q  <= req_signed;
                  off_q   <= req_addr[1:0];
                  wdata_q <= req_wdata;
                  err_q   <= req_err_d;
                  if (req_err_d) begin
                     state_q <= S_RESP;
                  end else if (req_we && (req_size == 2'b10)) begin
                     // Full-word store needs no read.
                     mem_address <= widx_d;
                     mem_data_in <= req_wdata;
                     mem_we      <= 1'b1;
                     state_q     <= S_WRITE;
                  end else begin
                     mem_address <= widx_d;
                     state_q     <= S_READ;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_READ: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               word_q <= mem_data_out;
               if (we_q) begin
                  mem_data_in <= store_merge(mem_data_out, wdata_q, size_q, off_q);
                  mem_we      <= 1'b1;
                  state_q     <= S_WRITE;
               end else begin
                  state_q <= S_RESP;
               end
            end
            S_WRITE: begin
               state_q <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b1;
               resp_err   <= err_q;
               resp_rdata <= (err_q || we_q) ? 32'd0
                                             : load_format(word_q, size_q, off_q, sign_q);
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [1:0]        req_size = 2'b00;
   logic              req_signed = 1'b0;
   logic [31:0]       req_addr = 32'd0;
   logic [31:0]       req_wdata = 32'd0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_data_in;
   logic              mem_we;
   logic [31:0]       mem_data_out = 32'd0;

   logic [31:0] mem [0:(1<<ADDR_W)-1];
   int wr_count = 0;
   int checks = 0;
   int errors = 0;

   dmem_lsu #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_we(mem_we), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   // Behavioural datamemory: synchronous write, registered read-first data.
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         mem[mem_address] <= mem_data_in;
         wr_count <= wr_count + 1;
      end
      mem_data_out <= mem[mem_address];
   end

   // Issue one request from IDLE and wait (bounded) for its response.
   task automatic issue_req(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat);
      req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_req addr=%h got=%b want=1", addr, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (lat < 12) begin
         @(posedge clk); #1;
         lat++;
         if (resp_valid === 1'b1) break;
      end
      rd = resp_rdata;
      er = resp_err;
      checks++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL resp_timeout addr=%h got=%b want=1", addr, resp_valid);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({resp_valid, resp_err, mem_we, req_ready} !== 4'b0001 || resp_rdata !== 32'd0 ||
          mem_address !== 10'd0 || mem_data_in !== 32'd0) begin
         errors++;
         $display("FAIL reset_state got=%b/%h/%h want=0001/0/0",
                  {resp_valid, resp_err, mem_we, req_ready}, resp_rdata, mem_data_in);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat; int w0;
      w0 = wr_count;
      issue_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
      checks++;
      if (lat != 2 || er !== 1'b0 || rd !== 32'd0 || wr_count != w0 + 1 || mem[4] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_store got lat=%0d err=%b rd=%h wr=%0d mem=%h want 2/0/0/%0d/deadbeef",
                  lat, er, rd, wr_count - w0, mem[4], 1);
      end
      issue_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
      checks++;
      if (lat != 3 || er !== 1'b0 || rd !== 32'hDEADBEEF || wr_count != w0 + 1) begin
         errors++;
         $display("FAIL word_load got lat=%0d err=%b rd=%h want 3/0/deadbeef", lat, er, rd);
      end
      // Upper address bits alias onto the same word.
      issue_req(1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         errors++;
         $display("FAIL alias_load got=%h want=deadbeef", rd);
      end
   endtask

   task automatic test_byte();
      logic [31:0] rd; logic er; int lat; int w0;
      issue_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
      w0 = wr_count;
      issue_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAA, rd, er, lat);
      checks++;
      if (lat != 4 || er !== 1'b0 || wr_count != w0 + 1 || mem[8] !== 32'h11AA3344) begin
         errors++;
         $display("FAIL byte_store got lat=%0d wr=%0d mem=%h want 4/1/11aa3344",
                  lat, wr_count - w0, mem[8]);
      end
      issue_req(1'b0, 2'b00, 1'b1, 32'h21, 32'd0, rd, er, lat);
      checks++;
      if (lat != 3 || rd !== 32'hFFFFFFAA) begin
         errors++;
         $display("FAIL byte_load_signed got lat=%0d rd=%h want 3/ffffffaa", lat, rd);
      end
      issue_req(1'b0, 2'b00, 1'b0, 32'h21, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'h000000AA) begin
         errors++;
         $display("FAIL byte_load_unsigned got=%h want=000000aa", rd);
      end
      issue_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_0080, rd, er, lat);
      checks++;
      if (mem[8] !== 32'h11AA3380) begin
         errors++;
         $display("FAIL byte_store_lane3 got=%h want=11aa3380", mem[8]);
      end
      issue_req(1'b0, 2'b00, 1'b1, 32'h23, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'hFFFFFF80) begin
         errors++;
         $display("FAIL byte80_signed got=%h want=ffffff80", rd);
      end
      issue_req(1'b0, 2'b00, 1'b0, 32'h23, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'h00000080) begin
         errors++;
         $display("FAIL byte80_unsigned got=%h want=00000080", rd);
      end
   endtask

   task automatic test_half();
      logic [31:0] rd; logic er; int lat;
      issue_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, rd, er, lat);
      issue_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_8001, rd, er, lat);
      checks++;
      if (lat != 4 || er !== 1'b0 || mem[12] !== 32'h12348001) begin
         errors++;
         $display("FAIL half_store got lat=%0d mem=%h want 4/12348001", lat, mem[12]);
      end
      issue_req(1'b0, 2'b01, 1'b1, 32'h32, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'hFFFF8001) begin
         errors++;
         $display("FAIL half_load_signed got=%h want=ffff8001", rd);
      end
      issue_req(1'b0, 2'b01, 1'b0, 32'h32, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'h00008001) begin
         errors++;
         $display("FAIL half_load_unsigned got=%h want=00008001", rd);
      end
      issue_req(1'b0, 2'b01, 1'b1, 32'h30, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'h00001234) begin
         errors++;
         $display("FAIL half_load_upper got=%h want=00001234", rd);
      end
      issue_req(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'h12348001) begin
         errors++;
         $display("FAIL half_word_readback got=%h want=12348001", rd);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat; int w0;
      logic [31:0] m1;
      w0 = wr_count;
      m1 = mem[0];
      issue_req(1'b0, 2'b10, 1'b0, 32'h05, 32'd0, rd, er, lat);
      checks++;
      if (lat != 1 || er !== 1'b1 || rd !== 32'd0) begin
         errors++;
         $display("FAIL err_word_misaligned got lat=%0d err=%b rd=%h want 1/1/0", lat, er, rd);
      end
      issue_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000_BEEF, rd, er, lat);
      checks++;
      if (lat != 1 || er !== 1'b1 || rd !== 32'd0) begin
         errors++;
         $display("FAIL err_half_misaligned got lat=%0d err=%b rd=%h want 1/1/0", lat, er, rd);
      end
      issue_req(1'b1, 2'b11, 1'b0, 32'h00, 32'h5555_5555, rd, er, lat);
      checks++;
      if (lat != 1 || er !== 1'b1 || rd !== 32'd0) begin
         errors++;
         $display("FAIL err_size11 got lat=%0d err=%b rd=%h want 1/1/0", lat, er, rd);
      end
      checks++;
      if (wr_count != w0 || mem[0] !== m1) begin
         errors++;
         $display("FAIL err_no_write got writes=%0d want=0", wr_count - w0);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat; int w0; int seen;
      issue_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788, rd, er, lat);
      w0 = wr_count;
      req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h40; req_wdata = 32'h0000_00CC; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;   // accepted, now READ
      @(posedge clk); #1;                     // now WAIT
      rst_n = 1'b0;
      #1;
      checks++;
      if ({resp_valid, resp_err, mem_we, req_ready} !== 4'b0001 || resp_rdata !== 32'd0 ||
          mem_address !== 10'd0 || mem_data_in !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got=%b addr=%h want=0001 addr=0",
                  {resp_valid, resp_err, mem_we, req_ready}, mem_address);
      end
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) seen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || req_ready !== 1'b1 || wr_count != w0 || mem[16] !== 32'h55667788) begin
         errors++;
         $display("FAIL reset_mid_abort got resp=%0d ready=%b mem=%h want 0/1/55667788",
                  seen, req_ready, mem[16]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int lat; int n; int cyc; int last; logic rdy;
      req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; req_valid = 1'b1;
      n = 0; cyc = 0; last = 0;
      while (n < 10 && cyc < 100) begin
         rdy = req_ready;
         @(posedge clk); #1;
         cyc++;
         if (rdy === 1'b1) begin
            if (n > 0) begin
               checks++;
               if (cyc - last != 3) begin
                  errors++;
                  $display("FAIL b2b_spacing idx=%0d got=%0d want=3", n, cyc - last);
               end
            end
            checks++;
            if (req_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_ready_busy idx=%0d got=%b want=0", n, req_ready);
            end
            last = cyc;
            n++;
            req_addr = 32'(4 * n);
            req_wdata = 32'(n);
         end
      end
      req_valid = 1'b0;
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL b2b_accepts got=%0d want=10", n);
      end
      repeat (3) begin @(posedge clk); #1; end
      for (int i = 0; i < 10; i++) begin
         issue_req(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'd0, rd, er, lat);
         checks++;
         if (rd !== 32'(i) || er !== 1'b0) begin
            errors++;
            $display("FAIL b2b_readback word=%0d got=%h want=%h", i, rd, 32'(i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
